seq_item_arbiter: RTL and testbench

- Round-robin arbiter that shares one driver-side item port between NUM_REQ sequence requesters.
- Sits between the sequence sources and the single bus driver. A grant is held for a whole multi-beat item, ending with the beat that has last=1.
- Hands the granted requester's beats to the driver through a valid/ready handshake.

---
 rtl/seq_item_arbiter.sv | 154 +++++++++++++++
 tb/tb_seq_item_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_item_arbiter.sv
// seq_item_arbiter: round-robin arbiter sharing one driver-side item port
// between NUM_REQ sequence requesters. A grant lasts for a whole multi-beat
// item, which ends on the beat with last=1. The owner's beats pass through
// to the driver combinationally under a valid/ready handshake.
//
// Optional feature: define SEQ_ITEM_ARBITER_LOCK_EN to add the req_lock
// input. The owner can then keep the grant across item boundaries without
// an idle bubble between items.

module seq_item_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      item_valid,
  output logic [DATA_W-1:0]         item_data,
  output logic                      item_last,
  input  logic                      item_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state_q,    state_d;
  logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  // Per-requester views of the flattened data bus.
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Round-robin search result.
  logic              win_found;
  logic [ID_W-1:0]   win_idx;

  // Handshake events for the current owner.
  logic              beat_fire;
  logic              last_fire;
  logic              hold_grant;

  // Split the flat data bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Pick the first requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    int              cand;
    logic [ID_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Beat and end-of-item detection for the granted requester.
  always_comb begin
    beat_fire = (state_q == XFER) && req_valid[grant_id_q] && item_ready;
    last_fire = beat_fire && req_last[grant_id_q];
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
    // Only the owner's lock bit matters; everyone else's is ignored.
    hold_grant = req_lock[grant_id_q];
`else
    hold_grant = 1'b0;
`endif
  end

  // State register: async reset aborts any item in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next-state logic: grant in IDLE, release on an unlocked last beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_id_d = win_idx;
          state_d    = XFER;
        end
      end
      XFER: begin
        // A locked owner keeps the grant and leaves rr_ptr untouched.
        if (last_fire && !hold_grant) begin
          rr_ptr_d = grant_id_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: quiet in IDLE, owner pass-through in XFER.
  always_comb begin
    req_ready  = '0;
    item_valid = 1'b0;
    item_data  = '0;
    item_last  = 1'b0;
    busy       = 1'b0;
    if (state_q == XFER) begin
      busy                  = 1'b1;
      item_valid            = req_valid[grant_id_q];
      item_data             = data_arr[grant_id_q];
      item_last             = req_last[grant_id_q];
      req_ready[grant_id_q] = item_ready;
    end
  end

  // grant_id keeps its last value in IDLE; it is meaningful only while busy.
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_seq_item_arbiter.sv
// Testbench for seq_item_arbiter. A behavioural model tracks the owner and
// the last winner, and checks every output on every falling edge. Directed
// scenarios pin the model with hand-computed values, and a randomized phase
// follows. Define SEQ_ITEM_ARBITER_LOCK_EN to also exercise the lock feature.

module tb_seq_item_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
  logic [N-1:0]    req_lock;
`endif
  logic [N-1:0]    req_ready;
  logic            item_valid;
  logic [DW-1:0]   item_data;
  logic            item_last;
  logic            item_ready;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_item_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .item_valid (item_valid),
    .item_data  (item_data),
    .item_last  (item_last),
    .item_ready (item_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // m_owner: index of the requester holding the grant, -1 when none.
  // m_ptr:   the requester that most recently completed an unlocked item.
  int            m_owner = -1;
  int            m_ptr   = N - 1;
  int            m_gid   = 0;
  logic [N-1:0]  e_ready;
  logic          e_valid;
  logic          e_last;
  logic          e_busy;
  logic [DW-1:0] e_data;
  int            e_gid;
  logic          e_hold;

  always @(negedge clk) begin
    e_ready = '0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_busy  = 1'b0;
    e_data  = '0;
    e_gid   = m_gid;
    e_hold  = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_gid   = 0;
      e_gid   = 0;
    end else if (m_owner >= 0) begin
      e_busy           = 1'b1;
      e_gid            = m_owner;
      e_valid          = req_valid[m_owner];
      e_last           = req_last[m_owner];
      e_data           = req_data[m_owner*DW +: DW];
      e_ready[m_owner] = item_ready;
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
      e_hold           = req_lock[m_owner];
`endif
    end

    check("model busy",       64'(busy),       64'(e_busy));
    check("model grant_id",   64'(grant_id),   64'(e_gid));
    check("model item_valid", 64'(item_valid), 64'(e_valid));
    check("model item_last",  64'(item_last),  64'(e_last));
    check("model item_data",  64'(item_data),  64'(e_data));
    check("model req_ready",  64'(req_ready),  64'(e_ready));

    // Advance to what the next rising edge must produce.
    if (rst_n) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_gid   = m_owner;
          end
        end
      end else if (e_valid && item_ready && e_last && !e_hold) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_data(input int r, input logic [DW-1:0] d);
    req_data[r*DW +: DW] = d;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [DW-1:0] exp_beat [5];
    logic          rdy_pat  [5];
    rst_n      = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    item_ready = 1'b0;
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
    req_lock   = '0;
`endif
    #1;
    rst_n = 1'b0;

    // Reset with all requesters asking: everything stays quiet.
    req_valid  = 4'b1111;
    req_last   = 4'b1111;
    item_ready = 1'b1;
    for (int r = 0; r < N; r++) set_data(r, 32'h100 + r);
    repeat (3) tick();
    settle();
    check("reset busy",       64'(busy),       64'd0);
    check("reset item_valid", 64'(item_valid), 64'd0);
    check("reset item_data",  64'(item_data),  64'd0);
    check("reset req_ready",  64'(req_ready),  64'd0);
    check("reset grant_id",   64'(grant_id),   64'd0);
    tick();
    rst_n = 1'b1;

    // Fair rotation of one-beat items: 0,1,2,3,0 with one bubble between.
    for (int k = 0; k < 9; k++) begin
      tick();
      settle();
      check("rot busy", 64'(busy), 64'((k % 2) == 0));
      if ((k % 2) == 0) check("rot grant_id", 64'(grant_id), 64'((k / 2) % N));
      if (k == 0) check("first req_ready", 64'(req_ready), 64'b0001);
    end
    tick();
    req_valid = '0;
    tick();

    // Multi-beat item from requester 2 under backpressure; 1 waits.
    exp_beat = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA2};
    rdy_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    req_valid  = 4'b0100;
    req_last   = 4'b0000;
    item_ready = 1'b0;
    set_data(2, 32'hA0);
    begin
      int beat;
      beat = 0;
      tick();
      for (int k = 0; k < 5; k++) begin
        req_valid   = 4'b0110;
        item_ready  = rdy_pat[k];
        set_data(2, 32'hA0 + beat);
        req_last[2] = (beat == 2);
        settle();
        check("mb item_data",    64'(item_data),    64'(exp_beat[k]));
        check("mb grant_id",     64'(grant_id),     64'd2);
        check("mb req_ready[1]", 64'(req_ready[1]), 64'd0);
        if (rdy_pat[k]) beat++;
        tick();
      end
    end
    req_valid  = 4'b0010;
    req_last   = 4'b0010;
    item_ready = 1'b1;
    set_data(1, 32'hB1);
    settle();
    check("mb bubble busy", 64'(busy), 64'd0);
    tick();
    settle();
    check("mb next grant",     64'(grant_id),  64'd1);
    check("mb next item_data", 64'(item_data), 64'hB1);
    tick();

    // Mid-item reset during beat 2 of a 4-beat item from requester 2.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    set_data(2, 32'hC0);
    tick();                 // granted 2, C0 on the bus
    tick();                 // C0 taken
    set_data(2, 32'hC1);
    tick();                 // C1 taken
    set_data(2, 32'hC2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async busy",       64'(busy),       64'd0);
    check("async item_valid", 64'(item_valid), 64'd0);
    check("async item_data",  64'(item_data),  64'd0);
    check("async req_ready",  64'(req_ready),  64'd0);
    check("async grant_id",   64'(grant_id),   64'd0);
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    check("post-reset grant", 64'(grant_id), 64'd0);
    check("post-reset busy",  64'(busy),     64'd1);
    tick();
    req_valid = '0;
    tick();

    // Owner stall: requester 3 drops req_valid mid-item for 5 cycles.
    req_valid  = 4'b1000;
    req_last   = 4'b0000;
    item_ready = 1'b1;
    set_data(3, 32'hD0);
    tick();
    settle();
    check("stall grant", 64'(grant_id), 64'd3);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("stall busy",       64'(busy),       64'd1);
      check("stall grant_id",   64'(grant_id),   64'd3);
      check("stall item_valid", 64'(item_valid), 64'd0);
      tick();
    end
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    set_data(3, 32'hD1);
    settle();
    check("resume item_valid", 64'(item_valid), 64'd1);
    check("resume item_data",  64'(item_data),  64'hD1);
    tick();
    req_valid = '0;
    tick();

`ifdef SEQ_ITEM_ARBITER_LOCK_EN
    // Lock: requester 1 keeps the grant for three items, then 2 wins.
    req_valid  = 4'b0110;
    req_last   = 4'b1111;
    item_ready = 1'b1;
    req_lock   = 4'b0010;
    tick();
    for (int k = 0; k < 3; k++) begin
      req_lock[1] = (k < 2);
      settle();
      check("lock busy",     64'(busy),     64'd1);
      check("lock grant_id", 64'(grant_id), 64'd1);
      tick();
    end
    req_lock = '0;
    settle();
    check("lock bubble", 64'(busy), 64'd0);
    tick();
    settle();
    check("lock next grant", 64'(grant_id), 64'd2);
    tick();
    req_valid = '0;
    tick();
`endif

    // Randomized phase: arbitrary inputs every cycle, model checks all.
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++) begin
        req_last[r] = ($urandom_range(0, 2) == 0);
        set_data(r, $urandom);
      end
      item_ready = ($urandom_range(0, 3) != 0);
`ifdef SEQ_ITEM_ARBITER_LOCK_EN
      req_lock = N'($urandom);
`endif
      if ($urandom_range(0, 399) == 0) begin
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    req_valid = '0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
